// File: rtl/pc_counter.sv
// pc_counter: loadable binary program counter built from cascaded 4-bit
// 74161-style slices. Feeds the address multiplexer 'a' inputs.
// Optional macro PC_SYNC_CLEAR_EN adds the clr_n port, a synchronous clear
// that overrides load and count (74163 behaviour).
// WIDTH must be a multiple of 4; each nibble is one slice.

// One 4-bit counter slice: clear > load > increment > hold.
module pc_counter_slice #(
  parameter logic [3:0] RST_NIB = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       all_ones
);
  logic [3:0] q_q, q_d;

  // Next-state selection for this nibble.
  always_comb begin
    q_d = q_q;
    if (clr)       q_d = 4'h0;
    else if (load) q_d = d;
    else if (inc)  q_d = q_q + 4'h1;
  end

  // Nibble register, asynchronously reset to its share of RESET_VALUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_NIB;
    else        q_q <= q_d;
  end

  assign q        = q_q;
  assign all_ones = &q_q;
endmodule

module pc_counter #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PC_SYNC_CLEAR_EN
  input  logic             clr_n,
`endif
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             ovf
);
  localparam int NUM_SLICES = WIDTH / 4;

  logic                  clr;
  logic                  load;
  logic                  cnt_en;
  logic                  q_max;
  logic [NUM_SLICES-1:0] slice_inc;
  logic [NUM_SLICES-1:0] slice_ones;
  logic                  ovf_q, ovf_d;

`ifdef PC_SYNC_CLEAR_EN
  assign clr = ~clr_n;
`else
  assign clr = 1'b0;
`endif

  assign load   = ~load_n;
  assign cnt_en = enp & ent;
  assign q_max  = &slice_ones;

  // Combinational carry chain: slice k steps only when every lower slice is F,
  // so the full counter advances in a single cycle like a WIDTH-bit adder.
  always_comb begin
    slice_inc[0] = cnt_en;
    for (int k = 1; k < NUM_SLICES; k++)
      slice_inc[k] = slice_inc[k-1] & slice_ones[k-1];
  end

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    pc_counter_slice #(
      .RST_NIB (RESET_VALUE[4*k +: 4])
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .inc      (slice_inc[k]),
      .d        (d[4*k +: 4]),
      .q        (q[4*k +: 4]),
      .all_ones (slice_ones[k])
    );
  end

  // Sticky wrap flag: set on a counting edge at all-ones, cleared by load/clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr || load)          ovf_d = 1'b0;
    else if (cnt_en && q_max) ovf_d = 1'b1;
  end

  // Wrap flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // Ripple carry ignores enp so external counters can cascade off it.
  assign rco = ent & q_max;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pc_counter.sv
// Directed, table-driven bench for pc_counter (WIDTH=8, RESET_VALUE=0).
module tb_pc_counter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_n, enp, ent;
  logic [7:0] d;
  logic [7:0] q;
  logic       rco, ovf;
`ifdef PC_SYNC_CLEAR_EN
  logic       clr_n;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef PC_SYNC_CLEAR_EN
    .clr_n  (clr_n),
`endif
    .load_n (load_n),
    .enp    (enp),
    .ent    (ent),
    .d      (d),
    .q      (q),
    .rco    (rco),
    .ovf    (ovf)
  );

  typedef struct {
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_rco;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on negedge, sample 1 time unit after the following rising edge.
  task automatic step(input logic ld_n, input logic p, input logic t, input logic [7:0] dv);
    @(negedge clk);
    load_n = ld_n; enp = p; ent = t; d = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        load_n enp ent d      q      rco  ovf
    vecs[0]  = '{1'b0, 1, 1, 8'h0E, 8'h0E, 1'b0, 1'b0}; // load nibble-carry start
    vecs[1]  = '{1'b1, 1, 1, 8'h55, 8'h0F, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1, 1, 8'h55, 8'h10, 1'b0, 1'b0}; // carry into upper nibble
    vecs[3]  = '{1'b1, 1, 1, 8'h55, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1, 1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1, 1, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1, 0, 8'h00, 8'hFF, 1'b0, 1'b0}; // ent=0 masks rco, holds
    vecs[7]  = '{1'b1, 1, 1, 8'h00, 8'h00, 1'b0, 1'b1}; // wrap sets ovf
    vecs[8]  = '{1'b1, 1, 1, 8'h00, 8'h01, 1'b0, 1'b1}; // ovf sticky
    vecs[9]  = '{1'b1, 0, 1, 8'hC3, 8'h01, 1'b0, 1'b1}; // d ignored without load
    vecs[10] = '{1'b0, 1, 1, 8'hFF, 8'hFF, 1'b1, 1'b0}; // load clears ovf
    vecs[11] = '{1'b0, 1, 1, 8'hA5, 8'hA5, 1'b0, 1'b0}; // load beats wrap at FF
    vecs[12] = '{1'b0, 0, 0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 0, 1, 8'h12, 8'hFF, 1'b1, 1'b0}; // hold, rco ignores enp
    vecs[14] = '{1'b1, 0, 1, 8'h34, 8'hFF, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 0, 1, 8'h56, 8'hFF, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 0, 1, 8'h78, 8'hFF, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1, 1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1, 1, 8'h37, 8'h37, 1'b0, 1'b0};

    rst_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 8'h00;
`ifdef PC_SYNC_CLEAR_EN
    clr_n = 1'b1;
`endif
    #12;
    check("reset_q", q, 8'h00);
    check("reset_ovf", ovf, 1'b0);
    check("reset_rco", rco, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].d);
      check($sformatf("vec%0d_q", i),   q,   vecs[i].exp_q);
      check($sformatf("vec%0d_rco", i), rco, vecs[i].exp_rco);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
    end

    // Async reset mid-cycle at q=37, no clock edge involved.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_count_after_rst", q, 8'h01);

    // Async reset must also clear a set ovf.
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    check("pre_rst_ovf", ovf, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ovf_set", ovf, 1'b0);
    check("async_rst_q2", q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PC_SYNC_CLEAR_EN
    step(1'b0, 1'b0, 1'b0, 8'h33);
    check("clr_setup_q", q, 8'h33);
    @(negedge clk);
    clr_n = 1'b0; load_n = 1'b0; enp = 1'b1; ent = 1'b1; d = 8'h5A;
    @(posedge clk);
    #1;
    check("clr_over_load_q", q, 8'h00);
    check("clr_over_load_ovf", ovf, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
